// File: rtl/rej_ntt_sampler.sv
// Rejection sampler for Dilithium RejNTTPoly: slices the squeezed SHAKE byte stream
// into 3-byte little-endian candidates, masks bit 23 and keeps those below Q.
module rej_ntt_sampler #(
  parameter int DATA_IN_BITS = 64,
  parameter int COEF_W       = 23,
  parameter int Q            = 8380417,
  parameter int N            = 256,
  parameter int BUF_BITS     = 192
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_IN_BITS-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [COEF_W-1:0]       coef_out,
  output logic                    coef_valid,
  input  logic                    coef_ready,
  output logic [7:0]              coef_idx,
  output logic                    done
);

  localparam int CAND_BITS = 24;
  localparam int FILL_W    = $clog2(BUF_BITS + DATA_IN_BITS + 1);
  localparam int CNT_W     = $clog2(N + 1);
  localparam logic [COEF_W-1:0] Q_V = COEF_W'(Q);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_next;
  logic [BUF_BITS-1:0]   shreg, shreg_next, shreg_shift;
  logic [FILL_W-1:0]     fill, fill_next, fill_shift;
  logic [CNT_W-1:0]      count, count_next;
  logic [COEF_W-1:0]     coef_out_next, cand;
  logic [7:0]            idx_next;
  logic                  coef_valid_next, done_next, in_ready_next;
  logic                  handshake, extract;

  always_comb begin
    state_next      = state;
    shreg_next      = shreg;
    fill_next       = fill;
    count_next      = count;
    coef_out_next   = coef_out;
    coef_valid_next = coef_valid;
    idx_next        = coef_idx;
    done_next       = done;

    handshake   = coef_valid && coef_ready;
    extract     = (state == RUN) && (fill >= FILL_W'(CAND_BITS)) && (!coef_valid || coef_ready);
    cand        = shreg[COEF_W-1:0];
    shreg_shift = extract ? (shreg >> CAND_BITS) : shreg;
    fill_shift  = extract ? (fill - FILL_W'(CAND_BITS)) : fill;

    if (start) begin
      state_next      = RUN;
      shreg_next      = '0;
      fill_next       = '0;
      count_next      = '0;
      coef_valid_next = 1'b0;
      done_next       = 1'b0;
    end else if (state == RUN) begin
      count_next = count + CNT_W'(handshake);
      if (handshake && (count == CNT_W'(N - 1))) begin
        state_next      = DONE;
        done_next       = 1'b1;
        coef_valid_next = 1'b0;
        shreg_next      = '0;
        fill_next       = '0;
      end else begin
        // Shift out the consumed candidate first so the new word lands at fill-24.
        shreg_next = shreg_shift;
        fill_next  = fill_shift;
        if (in_valid) begin
          shreg_next = shreg_shift | (BUF_BITS'(in_data) << fill_shift);
          fill_next  = fill_shift + FILL_W'(DATA_IN_BITS);
        end
        if (extract && (cand < Q_V)) begin
          coef_out_next   = cand;
          coef_valid_next = 1'b1;
          idx_next        = count_next[7:0];
        end else if (handshake) begin
          coef_valid_next = 1'b0;
        end
      end
    end

    in_ready_next = (state_next == RUN) && (fill_next <= FILL_W'(DATA_IN_BITS));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      fill       <= '0;
      count      <= '0;
      coef_out   <= '0;
      coef_valid <= 1'b0;
      coef_idx   <= '0;
      done       <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      state      <= state_next;
      shreg      <= shreg_next;
      fill       <= fill_next;
      count      <= count_next;
      coef_out   <= coef_out_next;
      coef_valid <= coef_valid_next;
      coef_idx   <= idx_next;
      done       <= done_next;
      in_ready   <= in_ready_next;
    end
  end

endmodule

// File: tb/tb_rej_ntt_sampler.sv
// Directed self-checking bench for rej_ntt_sampler with a byte-stream RejNTTPoly model.
module tb_rej_ntt_sampler;

  localparam int Q = 8380417;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, coef_ready;
  logic [63:0] in_data;
  logic        in_ready, coef_valid, done;
  logic [22:0] coef_out;
  logic [7:0]  coef_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rej_ntt_sampler #(
    .DATA_IN_BITS(64),
    .COEF_W(23),
    .Q(8380417),
    .N(256),
    .BUF_BITS(192)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .coef_out(coef_out), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_idx(coef_idx), .done(done)
  );

  logic [22:0] got_coef[$];
  logic [7:0]  got_idx[$];
  logic [22:0] exp_coef[$];
  logic [63:0] words[$];
  int          widx;
  logic        prev_ready;
  int          cyc = 0;
  int          last_hs_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake seen mid-cycle completes at the next rising edge.
  always @(negedge clk)
    if (!rst && !start && coef_valid && coef_ready) begin
      got_coef.push_back(coef_out);
      got_idx.push_back(coef_idx);
      last_hs_cyc = cyc;
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    in_valid = 1'b0;
    tick();
    start = 1'b0;
    prev_ready = 1'b0;
    widx = 0;
    got_coef.delete();
    got_idx.delete();
  endtask

  task automatic gen_words(input int n, input logic [63:0] seed);
    logic [63:0] x;
    words.delete();
    x = seed;
    for (int i = 0; i < n; i++) begin
      x = x * 64'd6364136223846793005 + 64'd1442695040888963407;
      words.push_back(x ^ (x >> 29));
    end
  endtask

  task automatic build_model(input int nw);
    logic [7:0]  bytes[$];
    logic [63:0] w;
    logic [22:0] c;
    exp_coef.delete();
    for (int i = 0; i < nw; i++) begin
      w = words[i];
      for (int b = 0; b < 8; b++) bytes.push_back(w[8*b +: 8]);
    end
    for (int i = 0; i + 2 < bytes.size(); i += 3) begin
      c = {bytes[i+2][6:0], bytes[i+1], bytes[i]};
      if (int'(c) < Q) exp_coef.push_back(c);
    end
  endtask

  // Sponge with one cycle out_ready -> out_valid latency.
  task automatic sponge_cycle();
    tick();
    if (in_valid) widx++;
    in_valid = prev_ready && (widx < words.size());
    in_data  = in_valid ? words[widx] : '0;
    prev_ready = in_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; coef_ready = 1'b0; in_data = '0;
    prev_ready = 1'b0; widx = 0;
    #1;
    checks++;
    if ({in_ready, coef_valid, done} !== 3'b000 || coef_out !== 23'd0 || coef_idx !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b val=%b done=%b out=%0d idx=%0d, expected all 0",
               in_ready, coef_valid, done, coef_out, coef_idx);
    end
    tick(); tick();
    rst = 1'b0;
    in_valid = 1'b1; in_data = 64'h0000_0000_0005_0001; coef_ready = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    checks++;
    if (coef_valid !== 1'b0 || in_ready !== 1'b0 || got_coef.size() != 0) begin
      errors++;
      $display("FAIL idle_ignore: got val=%b rdy=%b ncoef=%0d, expected 0 0 0",
               coef_valid, in_ready, got_coef.size());
    end
  endtask

  task automatic test_basic();
    coef_ready = 1'b1;
    do_start();
    in_valid = 1'b1; in_data = 64'h0000_0000_0005_0001;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (coef_valid !== 1'b1 || coef_out !== 23'h050001 || coef_idx !== 8'd0) begin
      errors++;
      $display("FAIL basic_latency: got val=%b out=%0d idx=%0d, expected 1 327681 0",
               coef_valid, coef_out, coef_idx);
    end
    tick();
    checks++;
    if (coef_valid !== 1'b1 || coef_out !== 23'd0 || coef_idx !== 8'd1) begin
      errors++;
      $display("FAIL basic_second: got val=%b out=%0d idx=%0d, expected 1 0 1",
               coef_valid, coef_out, coef_idx);
    end
    repeat (3) tick();
    checks++;
    if (coef_valid !== 1'b0 || got_coef.size() != 2) begin
      errors++;
      $display("FAIL basic_drain: got val=%b ncoef=%0d, expected 0 2", coef_valid, got_coef.size());
    end
  endtask

  task automatic test_reject();
    logic [22:0] ec[3];
    ec[0] = 23'd8380416; ec[1] = 23'd5; ec[2] = 23'd0;
    coef_ready = 1'b1;
    do_start();
    in_valid = 1'b1; in_data = 64'hFFFF_7FE0_017F_E000;
    tick();
    in_data = 64'h0000_0000_8000_05FF;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    checks++;
    if (got_coef.size() != 3) begin
      errors++;
      $display("FAIL reject_count: got %0d coefs, expected 3", got_coef.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_coef[i] !== ec[i] || got_idx[i] !== 8'(i)) begin
          errors++;
          $display("FAIL reject_coef%0d: got %0d idx %0d, expected %0d idx %0d",
                   i, got_coef[i], got_idx[i], ec[i], i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    gen_words(12, 64'h0123_4567_89AB_CDEF);
    build_model(12);
    coef_ready = 1'b0;
    do_start();
    repeat (6) sponge_cycle();
    for (int c = 0; c < 10; c++) begin
      sponge_cycle();
      checks++;
      if (coef_valid !== 1'b1 || coef_out !== exp_coef[0]) begin
        errors++;
        $display("FAIL bp_hold_c%0d: got val=%b out=%0d, expected 1 %0d", c, coef_valid, coef_out, exp_coef[0]);
      end
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_in_ready: got %b, expected 0", in_ready);
    end
    coef_ready = 1'b1;
    repeat (80) sponge_cycle();
    in_valid = 1'b0;
    checks++;
    if (widx != 12 || got_coef.size() != exp_coef.size()) begin
      errors++;
      $display("FAIL bp_stream_len: got words=%0d coefs=%0d, expected 12 %0d", widx, got_coef.size(), exp_coef.size());
    end else begin
      for (int i = 0; i < exp_coef.size(); i++) begin
        checks++;
        if (got_coef[i] !== exp_coef[i] || got_idx[i] !== 8'(i)) begin
          errors++;
          $display("FAIL bp_coef%0d: got %0d idx %0d, expected %0d idx %0d",
                   i, got_coef[i], got_idx[i], exp_coef[i], i);
        end
      end
    end
  endtask

  task automatic test_full_poly();
    logic seen_done;
    gen_words(120, 64'hDEAD_BEEF_0BAD_F00D);
    coef_ready = 1'b1;
    do_start();
    seen_done = 1'b0;
    for (int c = 0; c < 1500 && !seen_done; c++) begin
      sponge_cycle();
      if (done) seen_done = 1'b1;
    end
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL full_timeout: got done=0 after 1500 cycles, expected 1");
    end
    checks++;
    if (last_hs_cyc != cyc - 1 || in_ready !== 1'b0 || coef_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_done_timing: got hs_cyc=%0d cyc=%0d rdy=%b val=%b, expected hs_cyc=cyc-1 rdy=0 val=0",
               last_hs_cyc, cyc, in_ready, coef_valid);
    end
    build_model(widx);
    checks++;
    if (got_coef.size() != 256 || exp_coef.size() < 256) begin
      errors++;
      $display("FAIL full_count: got %0d coefs (model %0d), expected 256", got_coef.size(), exp_coef.size());
    end else begin
      for (int i = 0; i < 256; i++) begin
        checks++;
        if (got_coef[i] !== exp_coef[i] || got_idx[i] !== 8'(i)) begin
          errors++;
          $display("FAIL full_coef%0d: got %0d idx %0d, expected %0d idx %0d",
                   i, got_coef[i], got_idx[i], exp_coef[i], i);
        end
      end
    end
    in_valid = 1'b1; in_data = 64'h0000_0000_0001_0002;
    repeat (5) tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (done !== 1'b1 || coef_valid !== 1'b0 || in_ready !== 1'b0 || got_coef.size() != 256) begin
      errors++;
      $display("FAIL full_after_done: got done=%b val=%b rdy=%b ncoef=%0d, expected 1 0 0 256",
               done, coef_valid, in_ready, got_coef.size());
    end
  endtask

  task automatic test_restart();
    gen_words(60, 64'h5555_AAAA_3333_CCCC);
    coef_ready = 1'b1;
    do_start();
    for (int c = 0; c < 1000 && got_coef.size() < 100; c++) sponge_cycle();
    checks++;
    if (got_coef.size() < 100) begin
      errors++;
      $display("FAIL restart_timeout: got %0d coefs, expected 100", got_coef.size());
    end
    start = 1'b1; in_valid = 1'b1; in_data = 64'h0000_0000_0077_7777;
    tick();
    start = 1'b0; in_valid = 1'b0;
    got_coef.delete(); got_idx.delete();
    checks++;
    if (coef_valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear: got val=%b done=%b rdy=%b, expected 0 0 1", coef_valid, done, in_ready);
    end
    in_valid = 1'b1; in_data = 64'h0000_0000_0012_3456;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    checks++;
    if (got_coef.size() != 2) begin
      errors++;
      $display("FAIL restart_count: got %0d coefs, expected 2", got_coef.size());
    end else begin
      checks++;
      if (got_coef[0] !== 23'h123456 || got_idx[0] !== 8'd0 || got_coef[1] !== 23'd0 || got_idx[1] !== 8'd1) begin
        errors++;
        $display("FAIL restart_coefs: got %0d/%0d %0d/%0d, expected 1193046/0 0/1",
                 got_coef[0], got_idx[0], got_coef[1], got_idx[1]);
      end
    end
  endtask

  task automatic test_async_reset();
    coef_ready = 1'b0;
    do_start();
    in_valid = 1'b1; in_data = 64'h0000_0000_0005_0001;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checks++;
    if (coef_valid !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got val=%b rdy=%b, expected 1 1", coef_valid, in_ready);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (coef_valid !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || coef_out !== 23'd0) begin
      errors++;
      $display("FAIL areset_immediate: got val=%b rdy=%b done=%b out=%0d, expected 0 0 0 0",
               coef_valid, in_ready, done, coef_out);
    end
    #1 rst = 1'b0;
    tick();
    coef_ready = 1'b1;
    in_valid = 1'b1; in_data = 64'h0000_0000_0009_0009;
    repeat (4) tick();
    in_valid = 1'b0;
    checks++;
    if (coef_valid !== 1'b0 || in_ready !== 1'b0 || got_coef.size() != 0) begin
      errors++;
      $display("FAIL areset_idle: got val=%b rdy=%b ncoef=%0d, expected 0 0 0",
               coef_valid, in_ready, got_coef.size());
    end
    do_start();
    in_valid = 1'b1; in_data = 64'h0000_0000_0005_0001;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (got_coef.size() != 2 || got_coef[0] !== 23'h050001) begin
      errors++;
      $display("FAIL areset_resume: got %0d coefs, first %0d, expected 2 327681",
               got_coef.size(), (got_coef.size() > 0) ? got_coef[0] : 23'd0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reject();
    test_backpressure();
    test_full_poly();
    test_restart();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rej_ntt_sampler.md
Name: rej_ntt_sampler

Overview:
- Downstream consumer of the SHAKE sponge squeeze port. Turns the squeezed byte stream into uniform coefficients mod q by rejection sampling, for Dilithium RejNTTPoly / ExpandA.
- Takes 64-bit squeeze words, splits them into 3-byte little-endian candidates, masks bit 23, and emits each candidate < Q.
- Stops after N accepted coefficients, which fill one polynomial.

Parameters:
- DATA_IN_BITS, 64, width of squeeze word from sponge
- COEF_W, 23, coefficient width
- Q, 8380417, modulus; candidates >= Q are rejected
- N, 256, coefficients per polynomial
- BUF_BITS, 192, byte buffer capacity (3 squeeze words)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse: clear buffer and count, begin a new polynomial
- in_data  in  DATA_IN_BITS  squeeze word (sponge data_out)
- in_valid  in  1  in_data valid this cycle (sponge out_valid)
- in_ready  out  1  request more words (drives sponge out_ready)
- coef_out  out  COEF_W  accepted coefficient
- coef_valid  out  1  coef_out valid
- coef_ready  in  1  downstream accepts coef_out
- coef_idx  out  8  index 0..N-1 of the coefficient being presented
- done  out  1  high from the cycle after the N-th handshake until start or rst

Behaviour:
- Reset (async, immediate): state=IDLE, buffer fill=0, count=0; in_ready=0, coef_valid=0, coef_out=0, coef_idx=0, done=0.
- States:
  - IDLE: in_valid words are ignored; start -> RUN.
  - RUN: on the N-th coefficient handshake -> DONE.
  - DONE: start -> RUN.
  - start in any state, including mid-RUN: clears buffer, fill, count, coef_valid and done -> RUN. start has priority over every other same-cycle event, and an in_valid word in that cycle is dropped.
- Buffer ordering: a little-endian shift buffer. The byte at bit 0 is the oldest byte.
- Word append: in RUN, every in_valid word is written at bit position fill, and fill += 64. A word is never dropped in RUN.
- in_ready (registered) = (state==RUN) && (fill_next <= 64). This guarantees room for the word already in flight from the sponge's one-cycle out_ready->out_valid latency plus one more.
- Extraction, in RUN: when fill >= 24 and the output register is empty or being consumed this cycle (coef_valid && coef_ready):
  - cand = buf[22:0] (buf[23] discarded);
  - buffer shifts right 24 and fill -= 24;
  - if cand < Q: coef_out <= cand, coef_valid <= 1, coef_idx <= count;
  - else: coef_valid <= 0 unless already holding a value, and nothing is emitted.
  - At most one extraction per cycle.
- Same-cycle extract and append: the shift is applied first. The new word lands at position fill-24, and fill_next = fill - 24 + 64.
- Output handshake: coef_out and coef_valid are held stable while coef_valid && !coef_ready. count increments on each handshake.
- End of polynomial, on the N-th handshake (count reaches N):
  - state -> DONE and done <= 1;
  - coef_valid <= 0 and in_ready <= 0;
  - residual buffered bytes are discarded (fill <= 0);
  - words arriving in DONE (sponge skid) are dropped.
- Latency: with an empty buffer and coef_ready=1, a word accepted at edge t gives its first coefficient with coef_valid=1 after edge t+1. Sustained throughput is one candidate per cycle, and the buffer never overflows (fill <= 192).
- Comparison is unsigned, 23-bit cand against Q, so cand = Q-1 is accepted and cand = Q is rejected.

Test Plan:
- Basic extraction: start, then word 64'h0000_0000_0005_0001 (bytes 01 00 05 | 00 00 00 ...) with coef_ready=1 -> coef 0x050001 (327681), idx 0, then coef 0, idx 1.
- Rejection and boundary: candidates with bytes 00 E0 7F, 01 E0 7F, FF FF FF, 05 00 80 -> emits 8380416, rejects 8380417, rejects 0x7FFFFF (bit-23 masked), emits 5; idx 0, -, -, 1.
- Backpressure: coef_ready=0 for 10 cycles while in_valid words keep arriving each cycle after in_ready falls -> coef_out held constant; in_ready=0 once fill > 64; fill never exceeds 192; no word is lost, checked against a reference byte stream.
- Full polynomial: random squeeze stream checked against a software RejNTTPoly model -> exactly 256 coefficients matching, idx 0..255, done=1 the cycle after the last handshake, in_ready=0, and later in_valid words are ignored.
- Mid-operation restart: start pulsed after 100 coefficients while a word arrives in the same cycle -> count=0, buffer empty, that word dropped, next coefficient comes from the next word with idx 0.
- Async reset: assert rst between clock edges mid-RUN -> coef_valid, in_ready and done go to 0 immediately; the block stays IDLE until start.
